// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and the parity rule
// that both the transmitter and the receiver use.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // odd = 0: XOR of data (even parity); odd = 1: XNOR of data (odd parity)
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 11-bit frames (start, 8 data LSB first, parity, stop) into bytes,
// with parity/framing status and a one-cycle rx_valid pulse per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 6000000,
  parameter int BAUD_RATE = 600000,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(DATA_BITS - 1);

  rx_state_t              state, state_next;
  logic                   rx_s;
  logic [CNT_W-1:0]       clk_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_bit;
  logic                   bit_hit;
  logic                   cnt_clr;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_hit = (clk_cnt == BIT_LAST);
  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // cnt_clr is raised at every sample point and in the waiting states, so clk_cnt never wraps
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_next = ST_START;
      end
      ST_START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          cnt_clr = 1'b1;
          if (bit_cnt == BIT_MAX) state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bit_hit) begin
          cnt_clr    = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      clk_cnt  <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (state == ST_START) bit_cnt <= '0;
      if (state == ST_DATA && bit_hit) begin
        shift_reg[bit_cnt] <= rx_s;
        if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_PARITY && bit_hit) par_bit <= rx_s;
      if (state == ST_STOP && bit_hit) begin
        rx_data    <= shift_reg;
        parity_err <= (par_bit != parity_bit(shift_reg, PARITY != 0));
        frame_err  <= ~rx_s;
        rx_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an even-parity and an odd-parity receiver share one line.
module tb_uart_rx;

  localparam int unsigned CPB   = 6000000 / 600000;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned VALID_OFS = 2 + HALF + 10 * CPB;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned cyc;
  } exp_t;

  logic clk, reset, rx;
  logic [7:0] data_e, data_o;
  logic valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  exp_t q_e[$];
  exp_t q_o[$];
  exp_t last_e, last_o;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  uart_rx #(.CLK_FREQ(6000000), .BAUD_RATE(600000), .PARITY(0)) dut_even (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(data_e), .rx_valid(valid_e),
    .parity_err(perr_e), .frame_err(ferr_e), .rx_busy(busy_e)
  );

  uart_rx #(.CLK_FREQ(6000000), .BAUD_RATE(600000), .PARITY(1)) dut_odd (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(data_o), .rx_valid(valid_o),
    .parity_err(perr_o), .frame_err(ferr_o), .rx_busy(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_e) begin
      if (q_e.size() == 0) begin
        n_total++;
        $display("FAIL even_unexpected_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q_e.pop_front();
        chk("even_data", data_e, e.data);
        chk("even_parity_err", perr_e, e.perr);
        chk("even_frame_err", ferr_e, e.ferr);
        chk("even_valid_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_o) begin
      if (q_o.size() == 0) begin
        n_total++;
        $display("FAIL odd_unexpected_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q_o.pop_front();
        chk("odd_data", data_o, e.data);
        chk("odd_parity_err", perr_o, e.perr);
        chk("odd_frame_err", ferr_o, e.ferr);
        chk("odd_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_even_data", data_e, 0);
    chk("rst_even_valid", valid_e, 0);
    chk("rst_even_perr", perr_e, 0);
    chk("rst_even_ferr", ferr_e, 0);
    chk("rst_even_busy", busy_e, 0);
    chk("rst_odd_data", data_o, 0);
    chk("rst_odd_valid", valid_o, 0);
    chk("rst_odd_perr", perr_o, 0);
    chk("rst_odd_ferr", ferr_o, 0);
    chk("rst_odd_busy", busy_o, 0);
    last_e = '{data: 8'h00, perr: 1'b0, ferr: 1'b0, cyc: 0};
    last_o = last_e;
  endtask

  // Drives a whole frame starting at a negedge; extra low cycles follow a 0 stop bit.
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop,
                      input int unsigned low_tail);
    exp_t e;
    logic [10:0] f;
    f = {stop, pbit, d, 1'b0};
    e.data = d;
    e.ferr = ~stop;
    e.cyc  = cyc + 1 + VALID_OFS;
    e.perr = (pbit != (^d));
    q_e.push_back(e);
    last_e = e;
    e.perr = (pbit != ~(^d));
    q_o.push_back(e);
    last_o = e;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    if (!stop) repeat (low_tail) @(negedge clk);
  endtask

  initial begin
    logic [10:0] abort_f;
    logic [7:0]  d;
    logic        p, s;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    send(8'hA5, 1'b0, 1'b1, 0);
    send(8'h3C, 1'b1, 1'b1, 0);

    send(8'h55, 1'b0, 1'b0, 50);
    chk("break_even_busy", busy_e, 1);
    chk("break_odd_busy", busy_o, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_even_idle", busy_e, 0);
    chk("break_odd_idle", busy_o, 0);
    repeat (CPB) @(negedge clk);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_even_busy", busy_e, 0);
    chk("glitch_odd_busy", busy_o, 0);
    chk("glitch_even_data", data_e, last_e.data);
    chk("glitch_even_ferr", ferr_e, last_e.ferr);
    chk("glitch_odd_perr", perr_o, last_o.perr);

    send(8'h00, 1'b0, 1'b1, 0);
    send(8'hFF, 1'b0, 1'b1, 0);
    send(8'h81, 1'b0, 1'b1, 0);
    repeat (CPB) @(negedge clk);

    abort_f = {1'b1, 1'b0, 8'h12, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = abort_f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = abort_f[5];
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h34, 1'b1, 1'b1, 0);

    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom_range(0, 255));
      p = (^d) ^ 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send(d, p, s, $urandom_range(0, 20));
      if (!s) begin
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    rx = 1'b1;
    for (int i = 0; i < 400 && (q_e.size() != 0 || q_o.size() != 0); i++) @(negedge clk);
    chk("even_queue_drained", q_e.size(), 0);
    chk("odd_queue_drained", q_o.size(), 0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
